// File: rtl/lim_cntr_mc_if.sv
// Simple word-addressed register bus: single-cycle writes, combinational read data.
interface intbus_interf;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output wr, output wdata, input rdata);
    modport slave  (input addr, input wr, input wdata, output rdata);
endinterface

// File: rtl/lim_cntr_mc.sv
// Multi-channel out-of-range sample counter with per-channel peak tracking,
// interval snapshots, threshold alarms and an intbus register block.
module lim_cntr_mc #(
    parameter logic [31:0] BASEADDR      = 32'd0,
    parameter int          NCH           = 4,
    parameter int          IN_WIDTH      = 14,
    parameter int          OUT_WIDTH     = 8,
    parameter int          PERIOD_MAX_2N = 20,
    parameter int          CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    we,
    input  logic [NCH*IN_WIDTH-1:0] in,
    output logic                    irq,
    intbus_interf.slave             bus
);
    localparam logic [31:0]          ID_VALUE   = 32'h4C43_4D01;
    localparam int                   PW         = PERIOD_MAX_2N;
    localparam logic [4:0]           PERIOD_MAX = 5'(PERIOD_MAX_2N);
    localparam logic [PW-1:0]        ICNT_ONES  = '1;

    logic              en_reg;
    logic [4:0]        period_reg;
    logic [15:0]       thresh_reg;
    logic              done_reg;
    logic [15:0]       index_reg;
    logic [PW-1:0]     icnt_reg;

    logic [31:0]       offset;
    logic              wr_cfg;
    logic              wr_status;
    logic [4:0]        period_clamped;
    logic              restart;
    logic              sample_ok;
    logic [PW-1:0]     term_val;
    logic              terminal;
    logic [NCH-1:0]    alarm_vec;
    logic [31:0]       res_word [NCH];
    logic [31:0]       rdata;
    logic              unused_wdata;

    assign offset    = bus.addr - BASEADDR;
    assign wr_cfg    = bus.wr && (offset == 32'd1);
    assign wr_status = bus.wr && (offset == 32'd2);

    always_comb begin
        period_clamped = bus.wdata[5:1];
        if (period_clamped == 5'd0)
            period_clamped = 5'd1;
        else if (period_clamped > PERIOD_MAX)
            period_clamped = PERIOD_MAX;
    end

    // Any CLR or change of EN/PERIOD discards the partial interval; it also
    // overrides a coincident terminal cycle.
    assign restart   = wr_cfg && (bus.wdata[6] || (period_clamped != period_reg) ||
                                  (bus.wdata[0] != en_reg));
    assign sample_ok = we && en_reg;
    assign term_val  = ICNT_ONES >> (PW - int'(period_reg));
    assign terminal  = sample_ok && !restart && (icnt_reg == term_val);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_reg     <= 1'b0;
            period_reg <= PERIOD_MAX;
            thresh_reg <= 16'hFFFF;
            done_reg   <= 1'b0;
            index_reg  <= 16'd0;
            icnt_reg   <= '0;
        end else begin
            if (wr_cfg) begin
                en_reg     <= bus.wdata[0];
                period_reg <= period_clamped;
                thresh_reg <= bus.wdata[31:16];
            end
            if (restart)
                icnt_reg <= '0;
            else if (sample_ok)
                icnt_reg <= terminal ? '0 : icnt_reg + PW'(1);
            if (terminal)
                done_reg <= 1'b1;
            else if (wr_status && bus.wdata[0])
                done_reg <= 1'b0;
            if (terminal)
                index_reg <= index_reg + 16'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [IN_WIDTH-1:0]           x;
            logic [IN_WIDTH-OUT_WIDTH:0]   top_bits;
            logic                          over;
            logic [IN_WIDTH-1:0]           mag;
            logic [CNT_W-1:0]              cnt_reg;
            logic [CNT_W-1:0]              cnt_next;
            logic [IN_WIDTH-1:0]           peak_reg;
            logic [IN_WIDTH-1:0]           peak_next;
            logic [CNT_W-1:0]              res_cnt_reg;
            logic [IN_WIDTH-1:0]           res_peak_reg;
            logic                          alarm_reg;

            assign x        = in[gi*IN_WIDTH +: IN_WIDTH];
            assign top_bits = x[IN_WIDTH-1:OUT_WIDTH-1];
            assign over     = !((&top_bits) || !(|top_bits));
            // Unsigned negation: the most negative input lands on 2^(IN_WIDTH-1).
            assign mag       = x[IN_WIDTH-1] ? (~x + IN_WIDTH'(1)) : x;
            assign cnt_next  = (over && (cnt_reg != '1)) ? cnt_reg + CNT_W'(1) : cnt_reg;
            assign peak_next = (mag > peak_reg) ? mag : peak_reg;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cnt_reg      <= '0;
                    peak_reg     <= '0;
                    res_cnt_reg  <= '0;
                    res_peak_reg <= '0;
                    alarm_reg    <= 1'b0;
                end else if (restart) begin
                    cnt_reg  <= '0;
                    peak_reg <= '0;
                end else if (sample_ok) begin
                    if (terminal) begin
                        cnt_reg      <= '0;
                        peak_reg     <= '0;
                        res_cnt_reg  <= cnt_next;
                        res_peak_reg <= peak_next;
                        alarm_reg    <= (16'(cnt_next) >= thresh_reg);
                    end else begin
                        cnt_reg  <= cnt_next;
                        peak_reg <= peak_next;
                    end
                end
            end

            assign alarm_vec[gi] = alarm_reg;
            assign res_word[gi]  = {16'(res_peak_reg), 16'(res_cnt_reg)};
        end
    endgenerate

    always_comb begin
        rdata = '0;
        case (offset)
            32'd0:   rdata = ID_VALUE;
            32'd1:   rdata = {thresh_reg, 9'd0, 1'b0, period_reg, en_reg};
            32'd2:   rdata = {index_reg, 8'(alarm_vec), 7'd0, done_reg};
            default: begin
                for (int k = 0; k < NCH; k++)
                    if (offset == 32'(3 + k))
                        rdata = res_word[k];
            end
        endcase
    end

    assign bus.rdata    = rdata;
    assign irq          = done_reg;
    assign unused_wdata = ^bus.wdata[15:7];
endmodule

// File: tb/tb_lim_cntr_mc.sv
// Directed bench: dut1 is the default 4-channel build, dut2 a 1-channel
// CNT_W=4 build at base 0x100 for counter saturation.
module tb_lim_cntr_mc;
    logic        clk = 1'b0;
    logic        resetn;
    logic        we1, we2;
    logic [55:0] in1;
    logic [13:0] in2;
    logic        irq1, irq2;
    logic [31:0] d;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    intbus_interf bus1();
    intbus_interf bus2();

    lim_cntr_mc #(.BASEADDR(32'd0), .NCH(4), .IN_WIDTH(14), .OUT_WIDTH(8),
                  .PERIOD_MAX_2N(20), .CNT_W(16)) dut1 (
        .clk(clk), .resetn(resetn), .we(we1), .in(in1), .irq(irq1), .bus(bus1));

    lim_cntr_mc #(.BASEADDR(32'h100), .NCH(1), .IN_WIDTH(14), .OUT_WIDTH(8),
                  .PERIOD_MAX_2N(20), .CNT_W(4)) dut2 (
        .clk(clk), .resetn(resetn), .we(we2), .in(in2), .irq(irq2), .bus(bus2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int sel, input logic [31:0] a, input logic [31:0] v);
        if (sel == 1) begin
            bus1.addr = a; bus1.wdata = v; bus1.wr = 1'b1;
        end else begin
            bus2.addr = a; bus2.wdata = v; bus2.wr = 1'b1;
        end
        $display("wr bus%0d addr %h data %h", sel, a, v);
        tick();
        bus1.wr = 1'b0;
        bus2.wr = 1'b0;
    endtask

    task automatic rd(input int sel, input logic [31:0] a, output logic [31:0] v);
        if (sel == 1) bus1.addr = a;
        else          bus2.addr = a;
        #1;
        v = (sel == 1) ? bus1.rdata : bus2.rdata;
        $display("rd bus%0d addr %h data %h", sel, a, v);
    endtask

    task automatic smp1(input int c0, input int c1);
        in1 = {28'd0, 14'(c1), 14'(c0)};
        we1 = 1'b1;
        tick();
        we1 = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++; if (irq1 !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq1); else pass_cnt++;
        rd(1, 32'd0, d);
        total_cnt++; if (d !== 32'h4C43_4D01) $display("FAIL reset_id got %h exp 4c434d01", d); else pass_cnt++;
        rd(1, 32'd1, d);
        total_cnt++; if (d !== 32'hFFFF_0028) $display("FAIL reset_cfg got %h exp ffff0028", d); else pass_cnt++;
        rd(1, 32'd2, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL reset_status got %h exp 0", d); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            rd(1, 32'(3 + k), d);
            total_cnt++; if (d !== 32'h0) $display("FAIL reset_res%0d got %h exp 0", k, d); else pass_cnt++;
        end
    endtask

    task automatic test_clamp();
        wr(1, 32'd1, 32'hFFFF_0000);
        rd(1, 32'd1, d);
        total_cnt++; if (d !== 32'hFFFF_0002) $display("FAIL clamp_low got %h exp ffff0002", d); else pass_cnt++;
        wr(1, 32'd1, 32'hFFFF_003E);
        rd(1, 32'd1, d);
        total_cnt++; if (d !== 32'hFFFF_0028) $display("FAIL clamp_high got %h exp ffff0028", d); else pass_cnt++;
    endtask

    task automatic test_basic();
        int vals[8] = '{127, 128, -128, -129, 0, 8191, -8192, 5};
        wr(1, 32'd1, 32'hFFFF_0007);
        for (int i = 0; i < 7; i++) smp1(vals[i], 0);
        total_cnt++; if (irq1 !== 1'b0) $display("FAIL basic_irq_early got %b exp 0", irq1); else pass_cnt++;
        smp1(vals[7], 0);
        total_cnt++; if (irq1 !== 1'b1) $display("FAIL basic_irq got %b exp 1", irq1); else pass_cnt++;
        rd(1, 32'd3, d);
        total_cnt++; if (d !== 32'h2000_0004) $display("FAIL basic_res0 got %h exp 20000004", d); else pass_cnt++;
        rd(1, 32'd4, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL basic_res1 got %h exp 0", d); else pass_cnt++;
        rd(1, 32'd2, d);
        total_cnt++; if (d !== 32'h0001_0001) $display("FAIL basic_status got %h exp 00010001", d); else pass_cnt++;
        wr(1, 32'd2, 32'h1);
        total_cnt++; if (irq1 !== 1'b0) $display("FAIL basic_w1c got %b exp 0", irq1); else pass_cnt++;
    endtask

    task automatic test_alarm();
        wr(1, 32'd1, 32'h0008_0007);
        repeat (8) smp1(0, -129);
        rd(1, 32'd4, d);
        total_cnt++; if (d !== 32'h0081_0008) $display("FAIL alarm_res1 got %h exp 00810008", d); else pass_cnt++;
        rd(1, 32'd2, d);
        total_cnt++; if (d !== 32'h0002_0201) $display("FAIL alarm_set got %h exp 00020201", d); else pass_cnt++;
        wr(1, 32'd2, 32'h1);
        wr(1, 32'd1, 32'h0009_0007);
        repeat (8) smp1(0, -129);
        rd(1, 32'd2, d);
        total_cnt++; if (d !== 32'h0003_0001) $display("FAIL alarm_thresh9 got %h exp 00030001", d); else pass_cnt++;
        wr(1, 32'd2, 32'h1);
        repeat (8) smp1(0, 0);
        rd(1, 32'd4, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL alarm_quiet_res1 got %h exp 0", d); else pass_cnt++;
        rd(1, 32'd2, d);
        total_cnt++; if (d !== 32'h0004_0001) $display("FAIL alarm_quiet got %h exp 00040001", d); else pass_cnt++;
        wr(1, 32'd2, 32'h1);
    endtask

    task automatic test_saturate();
        wr(2, 32'h101, 32'hFFFF_000B);
        in2 = 14'h1000;
        repeat (31) begin
            we2 = 1'b1; tick(); we2 = 1'b0;
        end
        total_cnt++; if (irq2 !== 1'b0) $display("FAIL sat_irq_early got %b exp 0", irq2); else pass_cnt++;
        we2 = 1'b1; tick(); we2 = 1'b0;
        total_cnt++; if (irq2 !== 1'b1) $display("FAIL sat_irq got %b exp 1", irq2); else pass_cnt++;
        rd(2, 32'h103, d);
        total_cnt++; if (d !== 32'h1000_000F) $display("FAIL sat_res0 got %h exp 1000000f", d); else pass_cnt++;
    endtask

    task automatic test_period_change();
        repeat (3) smp1(200, 0);
        wr(1, 32'd1, 32'hFFFF_0009);
        repeat (15) smp1(200, 0);
        total_cnt++; if (irq1 !== 1'b0) $display("FAIL pchg_irq_early got %b exp 0", irq1); else pass_cnt++;
        smp1(200, 0);
        total_cnt++; if (irq1 !== 1'b1) $display("FAIL pchg_irq got %b exp 1", irq1); else pass_cnt++;
        rd(1, 32'd3, d);
        total_cnt++; if (d !== 32'h00C8_0010) $display("FAIL pchg_res0 got %h exp 00c80010", d); else pass_cnt++;
        rd(1, 32'd2, d);
        total_cnt++; if (d !== 32'h0005_0001) $display("FAIL pchg_status got %h exp 00050001", d); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // CLR on the terminal sample: no snapshot, DONE left as it was (1).
        repeat (15) smp1(300, 0);
        in1 = {42'd0, 14'(300)}; we1 = 1'b1;
        bus1.addr = 32'd1; bus1.wdata = 32'hFFFF_0049; bus1.wr = 1'b1;
        tick();
        we1 = 1'b0; bus1.wr = 1'b0;
        rd(1, 32'd3, d);
        total_cnt++; if (d !== 32'h00C8_0010) $display("FAIL clr_term_res0 got %h exp 00c80010", d); else pass_cnt++;
        rd(1, 32'd2, d);
        total_cnt++; if (d !== 32'h0005_0001) $display("FAIL clr_term_status got %h exp 00050001", d); else pass_cnt++;
        rd(1, 32'd1, d);
        total_cnt++; if (d !== 32'hFFFF_0009) $display("FAIL clr_reads0 got %h exp ffff0009", d); else pass_cnt++;
        // DONE clear on the terminal sample: set wins.
        repeat (15) smp1(300, 0);
        in1 = {42'd0, 14'(300)}; we1 = 1'b1;
        bus1.addr = 32'd2; bus1.wdata = 32'h1; bus1.wr = 1'b1;
        tick();
        we1 = 1'b0; bus1.wr = 1'b0;
        total_cnt++; if (irq1 !== 1'b1) $display("FAIL w1c_term_irq got %b exp 1", irq1); else pass_cnt++;
        rd(1, 32'd3, d);
        total_cnt++; if (d !== 32'h012C_0010) $display("FAIL w1c_term_res0 got %h exp 012c0010", d); else pass_cnt++;
        rd(1, 32'd2, d);
        total_cnt++; if (d !== 32'h0006_0001) $display("FAIL w1c_term_status got %h exp 00060001", d); else pass_cnt++;
        wr(1, 32'd2, 32'h1);
    endtask

    task automatic test_gapped();
        wr(1, 32'd1, 32'hFFFF_0007);
        for (int i = 0; i < 8; i++) begin
            smp1(1, 0);
            in1 = {42'd0, 14'(8191)};
            if (i < 7) begin
                tick(); tick();
            end
        end
        total_cnt++; if (irq1 !== 1'b1) $display("FAIL gap_irq got %b exp 1", irq1); else pass_cnt++;
        rd(1, 32'd3, d);
        total_cnt++; if (d !== 32'h0001_0000) $display("FAIL gap_res0 got %h exp 00010000", d); else pass_cnt++;
        wr(1, 32'd2, 32'h1);
        wr(1, 32'd1, 32'hFFFF_0006);
        repeat (10) smp1(200, 0);
        rd(1, 32'd2, d);
        total_cnt++; if (d !== 32'h0007_0000) $display("FAIL en0_status got %h exp 00070000", d); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        wr(1, 32'd1, 32'hFFFF_0007);
        repeat (8) smp1(200, 0);
        repeat (3) smp1(200, 0);
        #2 resetn = 1'b0;
        #1;
        total_cnt++; if (irq1 !== 1'b0) $display("FAIL rst_mid_irq got %b exp 0", irq1); else pass_cnt++;
        total_cnt++; if (irq2 !== 1'b0) $display("FAIL rst_mid_irq2 got %b exp 0", irq2); else pass_cnt++;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        rd(1, 32'd3, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL rst_mid_res0 got %h exp 0", d); else pass_cnt++;
        rd(1, 32'd1, d);
        total_cnt++; if (d !== 32'hFFFF_0028) $display("FAIL rst_mid_cfg got %h exp ffff0028", d); else pass_cnt++;
        rd(1, 32'd2, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL rst_mid_status got %h exp 0", d); else pass_cnt++;
        rd(2, 32'h103, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL rst_mid_dut2_res0 got %h exp 0", d); else pass_cnt++;
    endtask

    initial begin
        resetn = 1'b0;
        we1 = 1'b0; we2 = 1'b0; in1 = '0; in2 = '0;
        bus1.addr = '0; bus1.wdata = '0; bus1.wr = 1'b0;
        bus2.addr = '0; bus2.wdata = '0; bus2.wr = 1'b0;
        #12 resetn = 1'b1;
        tick();
        test_reset();
        test_clamp();
        test_basic();
        test_alarm();
        test_saturate();
        test_period_change();
        test_back_to_back();
        test_gapped();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
